// File: rtl/design1_wrapper_if.sv
// Bus bundle for the snoop devil: AXI4-Lite register port plus the ACE snoop AC/CR/CD channels.
interface design1_wrapper_if #(
  parameter int AW_LITE = 7,
  parameter int AC_AW   = 44
);
  logic [AW_LITE-1:0] s_awaddr;
  logic               s_awvalid;
  logic               s_awready;
  logic [31:0]        s_wdata;
  logic [3:0]         s_wstrb;
  logic               s_wvalid;
  logic               s_wready;
  logic [1:0]         s_bresp;
  logic               s_bvalid;
  logic               s_bready;
  logic [AW_LITE-1:0] s_araddr;
  logic               s_arvalid;
  logic               s_arready;
  logic [31:0]        s_rdata;
  logic [1:0]         s_rresp;
  logic               s_rvalid;
  logic               s_rready;
  logic [AC_AW-1:0]   acaddr_0;
  logic [3:0]         acsnoop_0;
  logic               acvalid_0;
  logic               acready_0;
  logic               crvalid_0;
  logic [4:0]         crresp_0;
  logic               crready_0;
  logic               cdvalid_0;
  logic [31:0]        cddata_0;
  logic               cdlast_0;
  logic               cdready_0;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    output acaddr_0, acsnoop_0, acvalid_0, crready_0, cdready_0,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid,
    input  acready_0, crvalid_0, crresp_0, cdvalid_0, cddata_0, cdlast_0
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    input  acaddr_0, acsnoop_0, acvalid_0, crready_0, cdready_0,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid,
    output acready_0, crvalid_0, crresp_0, cdvalid_0, cddata_0, cdlast_0
  );
endinterface

// File: rtl/design1_wrapper.sv
// Snoop-channel fault-injection controller: delays, forces or forges ACE snoop responses.
// Optional DEVIL_PDT_EN builds the PDT function and the CD data path.
module design1_wrapper #(
  parameter int AW_LITE = 7,
  parameter int AC_AW   = 44
) (
  input logic              clk_100MHz,
  input logic              reset,
  design1_wrapper_if.slave bus
);
  localparam logic [3:0] FUNC_OSH = 4'd0;
  localparam logic [3:0] FUNC_CON = 4'd1;
  localparam logic [3:0] FUNC_PDT = 4'd4;
  localparam logic [3:0] TEST_DELAY_CR = 4'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_DATA} state_t;

  logic [31:0] ctrl, delay, base_addr, mem_size;
  logic [3:0]  acsnoop_reg;
  logic        status_done;
  logic        aw_ready, b_valid, ar_ready, r_valid;
  logic [31:0] r_data, rd_val;
  logic        wr_fire, rd_fire, done_set;
  logic [4:0]  wr_idx, rd_idx;

  state_t      state;
  logic [31:0] wait_cnt;
  logic        ac_ready, cr_valid, osh_q, data_q, ac_fire;
  logic [4:0]  cr_resp;
  logic [3:0]  func;
  logic        func_ok, filt_ok, win_ok, hit;
  logic [AC_AW:0] win_lo, win_end;

`ifdef DEVIL_PDT_EN
  logic [31:0] wdata_reg [4];
  logic [31:0] snap [4];
  logic [31:0] cd_data;
  logic        cd_valid, cd_last;
  logic [1:0]  beat;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return res;
  endfunction

  assign wr_idx  = bus.s_awaddr[6:2];
  assign rd_idx  = bus.s_araddr[6:2];
  assign wr_fire = aw_ready && bus.s_awvalid && bus.s_wvalid;
  assign rd_fire = ar_ready && bus.s_arvalid;
  assign ac_fire = ac_ready && bus.acvalid_0;
  assign done_set = (state == ST_RESP) && bus.crready_0 && osh_q;

  assign bus.s_awready = aw_ready;
  assign bus.s_wready  = aw_ready;
  assign bus.s_bvalid  = b_valid;
  assign bus.s_bresp   = 2'b00;
  assign bus.s_arready = ar_ready;
  assign bus.s_rvalid  = r_valid;
  assign bus.s_rdata   = r_data;
  assign bus.s_rresp   = 2'b00;
  assign bus.acready_0 = ac_ready;
  assign bus.crvalid_0 = cr_valid;
  assign bus.crresp_0  = cr_resp;

`ifdef DEVIL_PDT_EN
  assign bus.cdvalid_0 = cd_valid;
  assign bus.cddata_0  = cd_data;
  assign bus.cdlast_0  = cd_last;
  logic unused_bits;
  assign unused_bits = ^{bus.s_awaddr[1:0], bus.s_araddr[1:0]};
`else
  assign bus.cdvalid_0 = 1'b0;
  assign bus.cddata_0  = '0;
  assign bus.cdlast_0  = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{bus.s_awaddr[1:0], bus.s_araddr[1:0], bus.cdready_0};
`endif

  // A DONE set on the CR handshake overrides a same-cycle W1C clear.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      ctrl        <= '0;
      delay       <= '0;
      base_addr   <= '0;
      mem_size    <= '0;
      acsnoop_reg <= '0;
      status_done <= 1'b0;
`ifdef DEVIL_PDT_EN
      for (int i = 0; i < 4; i++) wdata_reg[i] <= '0;
`endif
    end else begin
      if (wr_fire) begin
        case (wr_idx)
          5'h00: ctrl <= merge(ctrl, bus.s_wdata, bus.s_wstrb);
          5'h01: if (bus.s_wstrb[0] && bus.s_wdata[0]) status_done <= 1'b0;
          5'h02: delay <= merge(delay, bus.s_wdata, bus.s_wstrb);
          5'h03: if (bus.s_wstrb[0]) acsnoop_reg <= bus.s_wdata[3:0];
          5'h04: base_addr <= merge(base_addr, bus.s_wdata, bus.s_wstrb);
          5'h05: mem_size <= merge(mem_size, bus.s_wdata, bus.s_wstrb);
`ifdef DEVIL_PDT_EN
          5'h10, 5'h11, 5'h12, 5'h13:
            wdata_reg[wr_idx[1:0]] <= merge(wdata_reg[wr_idx[1:0]], bus.s_wdata, bus.s_wstrb);
`endif
          default: ;
        endcase
      end
      if (done_set) status_done <= 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      5'h00: rd_val = ctrl;
      5'h01: rd_val = {31'b0, status_done};
      5'h02: rd_val = delay;
      5'h03: rd_val = {28'b0, acsnoop_reg};
      5'h04: rd_val = base_addr;
      5'h05: rd_val = mem_size;
`ifdef DEVIL_PDT_EN
      5'h10, 5'h11, 5'h12, 5'h13: rd_val = wdata_reg[rd_idx[1:0]];
`endif
      default: rd_val = '0;
    endcase
  end

  // Ready is a one-cycle pulse, so only one write and one read can be outstanding.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      aw_ready <= 1'b0;
      b_valid  <= 1'b0;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      if (aw_ready) aw_ready <= 1'b0;
      else if (bus.s_awvalid && bus.s_wvalid && !b_valid) aw_ready <= 1'b1;
      if (wr_fire) b_valid <= 1'b1;
      else if (bus.s_bready) b_valid <= 1'b0;
      if (ar_ready) ar_ready <= 1'b0;
      else if (bus.s_arvalid && !r_valid) ar_ready <= 1'b1;
      if (rd_fire) begin
        r_valid <= 1'b1;
        r_data  <= rd_val;
      end else if (bus.s_rready) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    func    = ctrl[8:5];
    win_lo  = {{(AC_AW-31){1'b0}}, base_addr};
    win_end = {{(AC_AW-31){1'b0}}, base_addr} + {{(AC_AW-31){1'b0}}, mem_size};
    case (func)
      FUNC_OSH: func_ok = ctrl[16] && !status_done;
      FUNC_CON: func_ok = ctrl[17];
`ifdef DEVIL_PDT_EN
      FUNC_PDT: func_ok = ctrl[20];
`endif
      default:  func_ok = 1'b0;
    endcase
    filt_ok = !ctrl[14] || (bus.acsnoop_0 == acsnoop_reg);
    win_ok  = !ctrl[15] || (({1'b0, bus.acaddr_0} >= win_lo) && ({1'b0, bus.acaddr_0} < win_end));
    hit     = ctrl[0] && func_ok && filt_ok && win_ok;
  end

  // The decision, response code and forged data are frozen at the AC handshake.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ac_ready <= 1'b0;
      cr_valid <= 1'b0;
      cr_resp  <= '0;
      osh_q    <= 1'b0;
      data_q   <= 1'b0;
      wait_cnt <= '0;
`ifdef DEVIL_PDT_EN
      cd_valid <= 1'b0;
      cd_last  <= 1'b0;
      cd_data  <= '0;
      beat     <= '0;
      for (int i = 0; i < 4; i++) snap[i] <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          ac_ready <= 1'b1;
          if (ac_fire) begin
            ac_ready <= 1'b0;
            osh_q    <= hit && (func == FUNC_OSH);
            data_q   <= hit && (func == FUNC_PDT) && ctrl[9];
            cr_resp  <= hit ? ctrl[13:9] : 5'd0;
`ifdef DEVIL_PDT_EN
            for (int i = 0; i < 4; i++) snap[i] <= wdata_reg[i];
`endif
            if (hit && (ctrl[4:1] == TEST_DELAY_CR) && (delay != 32'd0)) begin
              state    <= ST_WAIT;
              wait_cnt <= delay - 32'd1;
            end else begin
              state    <= ST_RESP;
              cr_valid <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 32'd0) begin
            state    <= ST_RESP;
            cr_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 32'd1;
          end
        end
        ST_RESP: begin
          if (bus.crready_0) begin
            cr_valid <= 1'b0;
            cr_resp  <= '0;
`ifdef DEVIL_PDT_EN
            if (data_q) begin
              state    <= ST_DATA;
              cd_valid <= 1'b1;
              cd_data  <= snap[0];
              cd_last  <= 1'b0;
              beat     <= 2'd0;
            end else begin
              state    <= ST_IDLE;
              ac_ready <= 1'b1;
            end
`else
            state    <= ST_IDLE;
            ac_ready <= 1'b1;
`endif
          end
        end
        ST_DATA: begin
`ifdef DEVIL_PDT_EN
          if (bus.cdready_0) begin
            if (beat == 2'd3) begin
              cd_valid <= 1'b0;
              cd_last  <= 1'b0;
              cd_data  <= '0;
              state    <= ST_IDLE;
              ac_ready <= 1'b1;
            end else begin
              beat    <= beat + 2'd1;
              cd_data <= snap[beat + 2'd1];
              cd_last <= (beat == 2'd2);
            end
          end
`else
          state    <= ST_IDLE;
          ac_ready <= 1'b1;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_design1_wrapper.sv
// Randomized self-checking bench for design1_wrapper against a register-level behavioural model.
module tb_design1_wrapper;
`ifdef DEVIL_PDT_EN
  localparam bit PDT_BUILT = 1'b1;
`else
  localparam bit PDT_BUILT = 1'b0;
`endif

  logic tb_clk = 1'b0;
  logic reset;
  int   check_count = 0;
  int   error_count = 0;

  logic [31:0] sh_ctrl, sh_delay, sh_base, sh_size;
  logic [3:0]  sh_acsnoop;
  logic        sh_done;
  logic [31:0] sh_wdata [4];

  design1_wrapper_if #(.AW_LITE(7), .AC_AW(44)) bus ();

  design1_wrapper #(.AW_LITE(7), .AC_AW(44)) dut (
    .clk_100MHz(tb_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 tb_clk = ~tb_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic void clear_model();
    sh_ctrl = '0; sh_delay = '0; sh_base = '0; sh_size = '0;
    sh_acsnoop = '0; sh_done = 1'b0;
    for (int i = 0; i < 4; i++) sh_wdata[i] = '0;
  endfunction

  function automatic void model_write(input logic [6:0] addr, input logic [31:0] data);
    case (addr[6:2])
      5'h00: sh_ctrl = data;
      5'h01: if (data[0]) sh_done = 1'b0;
      5'h02: sh_delay = data;
      5'h03: sh_acsnoop = data[3:0];
      5'h04: sh_base = data;
      5'h05: sh_size = data;
      5'h10, 5'h11, 5'h12, 5'h13: if (PDT_BUILT) sh_wdata[addr[3:2]] = data;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [6:0] addr);
    case (addr[6:2])
      5'h00: return sh_ctrl;
      5'h01: return {31'b0, sh_done};
      5'h02: return sh_delay;
      5'h03: return {28'b0, sh_acsnoop};
      5'h04: return sh_base;
      5'h05: return sh_size;
      5'h10, 5'h11, 5'h12, 5'h13: return PDT_BUILT ? sh_wdata[addr[3:2]] : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic axi_write(input logic [6:0] addr, input logic [31:0] data);
    int n;
    bus.s_awaddr = addr; bus.s_wdata = data; bus.s_wstrb = 4'hF;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    n = 0;
    while (!bus.s_awready && n < 20) begin @(posedge tb_clk); #1; n++; end
    checkOutput("awready", bus.s_awready, 1);
    @(posedge tb_clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b1;
    n = 0;
    while (!bus.s_bvalid && n < 20) begin @(posedge tb_clk); #1; n++; end
    checkOutput("bvalid", bus.s_bvalid, 1);
    checkOutput("bresp", bus.s_bresp, 0);
    @(posedge tb_clk); #1;
    bus.s_bready = 1'b0;
    model_write(addr, data);
  endtask

  task automatic axi_read_check(input logic [6:0] addr);
    int n;
    bus.s_araddr = addr; bus.s_arvalid = 1'b1;
    n = 0;
    while (!bus.s_arready && n < 20) begin @(posedge tb_clk); #1; n++; end
    checkOutput("arready", bus.s_arready, 1);
    @(posedge tb_clk); #1;
    bus.s_arvalid = 1'b0; bus.s_rready = 1'b1;
    n = 0;
    while (!bus.s_rvalid && n < 20) begin @(posedge tb_clk); #1; n++; end
    checkOutput("rvalid", bus.s_rvalid, 1);
    checkOutput($sformatf("rdata@%02h", addr), bus.s_rdata, model_read(addr));
    checkOutput("rresp", bus.s_rresp, 0);
    @(posedge tb_clk); #1;
    bus.s_rready = 1'b0;
  endtask

  // One snoop end to end: predict from the register model, then check AC, CR and CD.
  task automatic applyStimulus(input logic [43:0] addr, input logic [3:0] snoop);
    logic [3:0]  func;
    logic        func_on, in_win, hit, exp_data;
    logic [63:0] a64, lo64, hi64;
    int          exp_lat, n;
    logic [4:0]  exp_resp;
    logic [31:0] exp_beats [4];

    func    = sh_ctrl[8:5];
    func_on = (func == 4'd0 && sh_ctrl[16]) || (func == 4'd1 && sh_ctrl[17]) ||
              (PDT_BUILT && func == 4'd4 && sh_ctrl[20]);
    a64     = {20'b0, addr};
    lo64    = {32'b0, sh_base};
    hi64    = lo64 + {32'b0, sh_size};
    in_win  = (a64 >= lo64) && (a64 < hi64);
    hit     = sh_ctrl[0] && func_on && (!sh_ctrl[14] || snoop == sh_acsnoop) &&
              (!sh_ctrl[15] || in_win) && !(func == 4'd0 && sh_done);
    exp_lat  = (hit && sh_ctrl[4:1] == 4'd1) ? 1 + int'(sh_delay) : 1;
    exp_resp = hit ? sh_ctrl[13:9] : 5'd0;
    exp_data = hit && func == 4'd4 && sh_ctrl[9];
    for (int i = 0; i < 4; i++) exp_beats[i] = sh_wdata[i];

    bus.acaddr_0 = addr; bus.acsnoop_0 = snoop; bus.acvalid_0 = 1'b1;
    n = 0;
    while (!bus.acready_0 && n < 20) begin @(posedge tb_clk); #1; n++; end
    checkOutput("acready", bus.acready_0, 1);
    @(posedge tb_clk); #1;
    bus.acvalid_0 = 1'b0;
    checkOutput("ac_busy", bus.acready_0, 0);
    n = 1;
    while (!bus.crvalid_0 && n < 200) begin @(posedge tb_clk); #1; n++; end
    checkOutput("cr_latency", n, exp_lat);
    checkOutput("crresp", bus.crresp_0, exp_resp);
    repeat ($urandom_range(0, 2)) begin
      @(posedge tb_clk); #1;
      checkOutput("cr_hold", bus.crvalid_0, 1);
      checkOutput("crresp_hold", bus.crresp_0, exp_resp);
    end
    bus.crready_0 = 1'b1;
    @(posedge tb_clk); #1;
    bus.crready_0 = 1'b0;
    if (hit && func == 4'd0) sh_done = 1'b1;
    checkOutput("cdvalid_first", bus.cdvalid_0, exp_data);
    if (exp_data) begin
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge tb_clk); #1;
        end
        checkOutput($sformatf("cdvalid_b%0d", b), bus.cdvalid_0, 1);
        checkOutput($sformatf("cddata_b%0d", b), bus.cddata_0, exp_beats[b]);
        checkOutput($sformatf("cdlast_b%0d", b), bus.cdlast_0, b == 3);
        bus.cdready_0 = 1'b1;
        @(posedge tb_clk); #1;
        bus.cdready_0 = 1'b0;
      end
      checkOutput("cdvalid_end", bus.cdvalid_0, 0);
    end
    checkOutput("ac_ready_back", bus.acready_0, 1);
  endtask

  initial begin
    logic [31:0] c, base, size;
    logic [63:0] a;
    logic [6:0]  ra;

    reset = 1'b1;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0; bus.acaddr_0 = '0; bus.acsnoop_0 = '0; bus.acvalid_0 = 1'b0;
    bus.crready_0 = 1'b0; bus.cdready_0 = 1'b0;
    clear_model();
    repeat (2) @(posedge tb_clk); #1;
    checkOutput("rst_acready", bus.acready_0, 0);
    checkOutput("rst_crvalid", bus.crvalid_0, 0);
    checkOutput("rst_cdvalid", bus.cdvalid_0, 0);
    checkOutput("rst_bvalid", bus.s_bvalid, 0);
    checkOutput("rst_rvalid", bus.s_rvalid, 0);
    reset = 1'b0;
    @(posedge tb_clk); #1;
    checkOutput("acready_after_reset", bus.acready_0, 1);
    axi_read_check(7'h00);
    axi_read_check(7'h04);

    $display("[TB] disabled snoop");
    applyStimulus(44'h0, 4'h1);

    $display("[TB] PDT window/filter");
    axi_write(7'h40, 32'hF0F0F0F0);
    axi_write(7'h44, 32'h00000001);
    axi_write(7'h48, 32'hFFFFFFFF);
    axi_write(7'h4C, 32'h00000002);
    axi_write(7'h10, 32'h40000000);
    axi_write(7'h14, 32'h00000004);
    axi_write(7'h0C, 32'h00000001);
    axi_write(7'h00, 32'h0010C281);
    axi_read_check(7'h00);
    axi_read_check(7'h48);
    applyStimulus(44'h000_4000_0000, 4'h1);
    applyStimulus(44'h000_4000_0004, 4'h1);
    applyStimulus(44'h000_4000_0000, 4'h2);

    $display("[TB] OSH one-shot with delay");
    axi_write(7'h08, 32'd2);
    axi_write(7'h00, 32'h00010003);
    applyStimulus(44'h123, 4'h0);
    axi_read_check(7'h04);
    applyStimulus(44'h456, 4'h0);
    axi_write(7'h04, 32'h1);
    axi_read_check(7'h04);

    $display("[TB] CON forced response");
    axi_write(7'h08, 32'd0);
    axi_write(7'h00, 32'h00023E21);
    repeat (3) applyStimulus(44'($urandom), 4'($urandom_range(0, 15)));
    axi_read_check(7'h04);

    axi_write(7'h24, 32'hDEADBEEF);
    axi_read_check(7'h24);
    axi_read_check(7'h50);

    $display("[TB] reset during response");
    bus.acaddr_0 = 44'h789; bus.acsnoop_0 = 4'h0; bus.acvalid_0 = 1'b1;
    @(posedge tb_clk); #1;
    bus.acvalid_0 = 1'b0;
    checkOutput("mid_crvalid", bus.crvalid_0, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_crvalid", bus.crvalid_0, 0);
    checkOutput("async_acready", bus.acready_0, 0);
    @(posedge tb_clk); #1;
    reset = 1'b0;
    clear_model();
    @(posedge tb_clk); #1;
    checkOutput("acready_after_reset2", bus.acready_0, 1);
    axi_read_check(7'h00);

    $display("[TB] randomized configurations");
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        base = 32'hFFFF_FFF0; size = 32'h40;
      end else begin
        base = $urandom & 32'hFFFF_F000; size = 32'($urandom_range(0, 64));
      end
      if (PDT_BUILT || $urandom_range(0, 1) == 0)
        for (int w = 0; w < 4; w++) axi_write(7'h40 + 7'(w * 4), $urandom);
      axi_write(7'h10, base);
      axi_write(7'h14, size);
      axi_write(7'h0C, 32'($urandom_range(0, 3)));
      axi_write(7'h08, 32'($urandom_range(0, 6)));
      if ($urandom_range(0, 2) == 0) axi_write(7'h04, 32'h1);
      c = '0;
      c[0]     = ($urandom_range(0, 7) != 0);
      c[4:1]   = 4'($urandom_range(0, 2));
      case ($urandom_range(0, 4))
        0: c[8:5] = 4'd0;
        1: c[8:5] = 4'd1;
        2, 3: c[8:5] = 4'd4;
        default: c[8:5] = 4'd2;
      endcase
      c[13:9]  = 5'($urandom);
      c[14]    = 1'($urandom);
      c[15]    = 1'($urandom);
      c[20:16] = 5'($urandom);
      axi_write(7'h00, c);
      for (int s = 0; s < 3; s++) begin
        if ($urandom_range(0, 3) != 0)
          a = {32'b0, base} + 64'($urandom_range(0, int'(size) + 8)) - 64'd4;
        else
          a = {20'b0, 44'($urandom)};
        applyStimulus(a[43:0], 4'($urandom_range(0, 3)));
      end
      ra = 7'($urandom_range(0, 31) * 4);
      axi_read_check(ra);
      axi_read_check(7'h04);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end
endmodule

// File: doc/design1_wrapper.md
# design1_wrapper

Snoop-channel fault-injection controller (“devil”) attached to the ACE snoop interface of a cached master. It is configured over an AXI4-Lite slave register file at system base 0x8001_0000. It answers incoming snoops (AC) on CR/CD and can delay them, force the CR response, or return forged line data. Snoops can be filtered by type and by address window.

## Interface
Parameters:
- `AW_LITE`, 7: AXI4-Lite address bits decoded (offsets 0x00–0x4C).
- `AC_AW`, 44: snoop address width.

Ports (clock and reset first):
- `clk_100MHz` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `s_awaddr`/`s_awvalid`/`s_awready`: AXI4-Lite write address; `s_awaddr` is `AW_LITE` bits.
- `s_wdata`/`s_wstrb`/`s_wvalid`/`s_wready`: write data, 32/4/1/1.
- `s_bresp`/`s_bvalid`/`s_bready`: 2/1/1.
- `s_araddr`/`s_arvalid`/`s_arready`: read address; `s_araddr` is `AW_LITE` bits.
- `s_rdata`/`s_rresp`/`s_rvalid`/`s_rready`: 32/2/1/1.
- `acaddr_0` in 44, `acsnoop_0` in 4, `acvalid_0` in 1, `acready_0` out 1: snoop request.
- `crvalid_0` out 1, `crresp_0` out 5, `crready_0` in 1: snoop response.
- `cdvalid_0` out 1, `cddata_0` out 32, `cdlast_0` out 1, `cdready_0` in 1: snoop data.

## Operation
- Registers (32-bit, R/W unless noted): CTRL 0x00; STATUS 0x04 (bit0 DONE, write-1-to-clear); DELAY 0x08; ACSNOOP 0x0C [3:0]; BASE_ADDR 0x10; MEM_SIZE 0x14; WDATA1..4 0x40/0x44/0x48/0x4C.
- Offsets 0x18–0x3C: writes are ignored; reads return 0. All other offsets read 0. BRESP and RRESP are always OKAY.
- CTRL fields:
  - EN [0]; TEST [4:1], where 1 = DELAY_CR; FUNC [8:5], where 0 = OSH, 1 = CON, 4 = PDT, and all other values are no-op.
  - CRRESP [13:9]; ACFLT [14]; ADDRFLT [15].
  - OSHEN [16], CONEN [17], PDTEN [20]. Bits 18/19 are stored but have no effect.
- Hit condition (all must hold):
  - EN = 1.
  - FUNC is valid and its matching enable bit is set.
  - If ACFLT: `acsnoop_0` == ACSNOOP[3:0].
  - If ADDRFLT: BASE_ADDR ≤ `acaddr_0` < BASE_ADDR + MEM_SIZE. BASE_ADDR is zero-extended to 44 bits; the sum is 45-bit with no wrap.
  - For OSH only: STATUS.DONE = 0.
- FSM states: IDLE → (AC handshake) → WAIT → RESP → [DATA] → IDLE.
- IDLE: `acready_0` = 1. On the AC handshake, latch the hit decision.
- Miss: go to RESP immediately; `crresp_0` = 0; no CD.
- Hit:
  - If TEST = DELAY_CR, WAIT holds DELAY cycles; otherwise WAIT holds 0 cycles.
  - RESP drives `crresp_0` = CTRL.CRRESP.
  - OSH additionally sets STATUS.DONE on the CR handshake.
  - PDT with CRRESP[0] = 1 enters DATA after the CR handshake.
- DATA: 4 beats, WDATA1 → WDATA4; `cdlast_0` asserts on beat 4. Each beat advances only on `cdready_0`.
- CON: every hit is manipulated; STATUS is never set.
- Register writes take effect for the next AC handshake. A transaction already in flight completes with its latched decision and data.

## Timing
- Reset values: all registers 0; `acready_0` 0 during reset and 1 on the first cycle after release; all CR/CD outputs 0; all AXI-Lite valid/ready outputs 0.
- AC handshake on cycle T → `crvalid_0` at T+1+D, where D = DELAY (hit with TEST = DELAY_CR) or 0 otherwise. DELAY = 0 gives T+1.
- `crvalid_0` and `crresp_0` are held until `crready_0`.
- First CD beat is the cycle after the CR handshake.
- `acready_0` is low from T+1 until return to IDLE.
- AXI-Lite:
  - AW and W are accepted together when both are valid; BVALID follows 1 cycle later and is held until BREADY.
  - Reads: RVALID 1 cycle after the AR handshake, held until RREADY. One outstanding transaction per direction.
  - A simultaneous STATUS W1C write and a DONE set: the set wins.
- Asynchronous `reset` mid-transaction returns the FSM to IDLE and drops all valids immediately.

## Configuration
- `DEVIL_PDT_EN`:
  - Defined: PDT function and the CD path are built.
  - Undefined: FUNC = 4 is a no-op (miss); `cdvalid_0`, `cddata_0` and `cdlast_0` are tied 0; WDATA1..4 read 0 and writes are ignored.

## Test plan
- Reset, then AC with EN = 0, `acsnoop_0` = 1 → `crvalid_0` 1 cycle after the handshake, `crresp_0` = 0, no CD.
- PDT setup:
  - WDATA = F0F0F0F0/00000001/FFFFFFFF/00000002; BASE 0x40000000, SIZE 4; ACSNOOP 1.
  - CTRL = CRRESP 1 | ACFLT | ADDRFLT | PDTEN | FUNC 4 | EN.
  - Snoop `acaddr_0` = 0x00040000000, `acsnoop_0` = 1 → `crresp_0` = 0x01, then 4 CD beats in that order with `cdlast_0` on beat 4.
- Same PDT setup with `acaddr_0` = 0x40000004 (outside the window), or with `acsnoop_0` = 2 → miss: `crresp_0` = 0, no CD.
- OSH: DELAY = 2, CTRL = TEST 1 | FUNC 0 | OSHEN | EN → first snoop gets CR at T+3 and STATUS reads 1. Second snoop → CR at T+1 with resp 0. Write STATUS = 1 → STATUS reads 0.
- CON with DELAY = 0 and CRRESP = 0x1F → every snoop returns 0x1F at T+1; STATUS stays 0.
- Read of 0x24 and of 0x50 → 0, RRESP OKAY.
